sm_config_loader: RTL and testbench



---
 rtl/sm_config_loader.sv | 210 +++++++++++++++++++++
 tb/tb_sm_config_loader.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sm_config_loader.sv
// Switch-matrix configuration loader: assembles a valid/ready word stream into a shadow image and commits it atomically to ConfigBits.
// Optional readback streaming of the committed image is enabled by defining SM_CONFIG_READBACK_EN.
module sm_config_loader #(
    parameter int NO_CONFIG_BITS = 12,
    parameter int WORD_WIDTH     = 8
) (
    input  logic                      CLK,
    input  logic                      reset,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [WORD_WIDTH-1:0]     s_data,
    input  logic                      s_last,
    output logic [NO_CONFIG_BITS-1:0] ConfigBits,
    output logic                      cfg_done,
    output logic                      cfg_err,
    output logic                      busy
`ifdef SM_CONFIG_READBACK_EN
    ,
    input  logic                      rb_req,
    output logic                      rb_valid,
    input  logic                      rb_ready,
    output logic [WORD_WIDTH-1:0]     rb_data,
    output logic                      rb_last
`endif
);

    localparam int N_WORDS = (NO_CONFIG_BITS + WORD_WIDTH - 1) / WORD_WIDTH;
    localparam int CNT_W   = $clog2(N_WORDS + 1);
    localparam int SH_W    = N_WORDS * WORD_WIDTH;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    state_t                    state_r;
    state_t                    state_next_s;
    logic [CNT_W-1:0]          count_r;
    logic [CNT_W-1:0]          idx_s;
    logic [SH_W-1:0]           shadow_r;
    logic [NO_CONFIG_BITS-1:0] config_bits_r;
    logic                      cfg_done_r;
    logic                      cfg_err_r;
    logic                      xfer_s;
    logic                      frame_err_s;
    logic                      s_ready_s;
    logic                      busy_s;

    // The first word of a frame always lands in slot 0, whatever the counter holds.
    assign idx_s  = (state_r == ST_IDLE) ? {CNT_W{1'b0}} : count_r;
    assign xfer_s = s_valid && s_ready_s;

    // State register.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic and frame-error detection.
    always_comb begin
        state_next_s = state_r;
        frame_err_s  = 1'b0;
        case (state_r)
            ST_IDLE, ST_LOAD: begin
                if (!xfer_s) begin
                    state_next_s = state_r;
                end else if (idx_s == LAST_IDX) begin
                    if (s_last) begin
                        state_next_s = ST_COMMIT;
                    end else begin
                        state_next_s = ST_DRAIN;
                        frame_err_s  = 1'b1;
                    end
                end else if (s_last) begin
                    state_next_s = ST_IDLE;
                    frame_err_s  = 1'b1;
                end else begin
                    state_next_s = ST_LOAD;
                end
            end
            ST_COMMIT: state_next_s = ST_IDLE;
            ST_DRAIN: begin
                if (xfer_s && s_last) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State-decoded handshake and status outputs.
    always_comb begin
        s_ready_s = (state_r != ST_COMMIT);
        busy_s    = (state_r != ST_IDLE);
    end

    // Shadow assembly, counter, atomic commit and status flags.
    always_ff @(posedge CLK) begin
        if (reset) begin
            shadow_r      <= {SH_W{1'b0}};
            count_r       <= {CNT_W{1'b0}};
            config_bits_r <= {NO_CONFIG_BITS{1'b0}};
            cfg_done_r    <= 1'b0;
            cfg_err_r     <= 1'b0;
        end else begin
            if (xfer_s && (state_r == ST_IDLE || state_r == ST_LOAD)) begin
                for (int k = 0; k < N_WORDS; k++) begin
                    if (idx_s == CNT_W'(k)) begin
                        shadow_r[k*WORD_WIDTH +: WORD_WIDTH] <= s_data;
                    end
                end
                count_r <= idx_s + CNT_W'(1);
            end else if (state_r == ST_COMMIT) begin
                count_r <= {CNT_W{1'b0}};
            end
            if (state_r == ST_COMMIT) begin
                config_bits_r <= shadow_r[NO_CONFIG_BITS-1:0];
            end
            cfg_done_r <= (state_r == ST_COMMIT);
            if (frame_err_s) begin
                cfg_err_r <= 1'b1;
            end else if (xfer_s && state_r == ST_IDLE) begin
                cfg_err_r <= 1'b0;
            end
        end
    end

    // Pad bits of the last word are stored but never reach ConfigBits.
    generate
        if (SH_W > NO_CONFIG_BITS) begin : g_pad
            logic pad_unused_s;
            assign pad_unused_s = ^shadow_r[SH_W-1:NO_CONFIG_BITS];
        end
    endgenerate

    assign s_ready    = s_ready_s;
    assign busy       = busy_s;
    assign ConfigBits = config_bits_r;
    assign cfg_done   = cfg_done_r;
    assign cfg_err    = cfg_err_r;

`ifdef SM_CONFIG_READBACK_EN
    logic [SH_W-1:0]       rb_snap_r;
    logic [SH_W-1:0]       cfg_pad_s;
    logic [CNT_W-1:0]      rb_idx_r;
    logic                  rb_valid_r;
    logic                  rb_last_r;
    logic [WORD_WIDTH-1:0] rb_data_r;

    function automatic logic [WORD_WIDTH-1:0] word_at(input logic [SH_W-1:0] img,
                                                      input logic [CNT_W-1:0] idx);
        logic [WORD_WIDTH-1:0] w;
        w = {WORD_WIDTH{1'b0}};
        for (int k = 0; k < N_WORDS; k++) begin
            if (idx == CNT_W'(k)) begin
                w = img[k*WORD_WIDTH +: WORD_WIDTH];
            end
        end
        return w;
    endfunction

    // Zero-extend the committed image to whole words.
    always_comb begin
        cfg_pad_s = {SH_W{1'b0}};
        cfg_pad_s[NO_CONFIG_BITS-1:0] = config_bits_r;
    end

    // Readback: snapshot on request, then stream words held until accepted.
    always_ff @(posedge CLK) begin
        if (reset) begin
            rb_snap_r  <= {SH_W{1'b0}};
            rb_idx_r   <= {CNT_W{1'b0}};
            rb_valid_r <= 1'b0;
            rb_last_r  <= 1'b0;
            rb_data_r  <= {WORD_WIDTH{1'b0}};
        end else if (!rb_valid_r) begin
            if (rb_req) begin
                rb_snap_r  <= cfg_pad_s;
                rb_idx_r   <= {CNT_W{1'b0}};
                rb_valid_r <= 1'b1;
                rb_data_r  <= cfg_pad_s[WORD_WIDTH-1:0];
                rb_last_r  <= (LAST_IDX == {CNT_W{1'b0}});
            end
        end else if (rb_ready) begin
            if (rb_last_r) begin
                rb_valid_r <= 1'b0;
                rb_last_r  <= 1'b0;
                rb_data_r  <= {WORD_WIDTH{1'b0}};
            end else begin
                rb_idx_r  <= rb_idx_r + CNT_W'(1);
                rb_data_r <= word_at(rb_snap_r, rb_idx_r + CNT_W'(1));
                rb_last_r <= ((rb_idx_r + CNT_W'(1)) == LAST_IDX);
            end
        end
    end

    assign rb_valid = rb_valid_r;
    assign rb_data  = rb_data_r;
    assign rb_last  = rb_last_r;
`endif

endmodule

// File: tb/tb_sm_config_loader.sv
// Directed bench for sm_config_loader (12 config bits, 8-bit words) with a commit scoreboard.
module tb_sm_config_loader;

    logic        CLK = 1'b0;
    logic        reset;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        s_last;
    logic [11:0] ConfigBits;
    logic        cfg_done;
    logic        cfg_err;
    logic        busy;
`ifdef SM_CONFIG_READBACK_EN
    logic        rb_req;
    logic        rb_valid;
    logic        rb_ready;
    logic [7:0]  rb_data;
    logic        rb_last;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [11:0] exp_q[$];

    always #5 CLK = ~CLK;

    sm_config_loader #(.NO_CONFIG_BITS(12), .WORD_WIDTH(8)) dut (
        .CLK        (CLK),
        .reset      (reset),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .ConfigBits (ConfigBits),
        .cfg_done   (cfg_done),
        .cfg_err    (cfg_err),
        .busy       (busy)
`ifdef SM_CONFIG_READBACK_EN
        ,
        .rb_req     (rb_req),
        .rb_valid   (rb_valid),
        .rb_ready   (rb_ready),
        .rb_data    (rb_data),
        .rb_last    (rb_last)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one word and hold it until the loader accepts it; returns #1 after the transfer edge.
    task automatic xfer(input logic [7:0] d, input logic l);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        while (s_ready !== 1'b1 && n < 20) begin
            @(posedge CLK);
            #1;
            n++;
        end
        chk("xfer_ready_wait", {31'd0, (n < 20)}, 32'd1);
        @(posedge CLK);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Called right after the final transfer: commit lands on the next edge, pulse lasts one cycle.
    task automatic check_commit(input string tag);
        logic [11:0] exp;
        @(posedge CLK);
        #1;
        chk({tag, "_done"}, {31'd0, cfg_done}, 32'd1);
        chk({tag, "_sb_nonempty"}, {31'd0, (exp_q.size() != 0)}, 32'd1);
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 12'h000;
        chk({tag, "_cfg"}, {20'd0, ConfigBits}, {20'd0, exp});
        chk({tag, "_ready_back"}, {31'd0, s_ready}, 32'd1);
        @(posedge CLK);
        #1;
        chk({tag, "_done_low"}, {31'd0, cfg_done}, 32'd0);
    endtask

    initial begin
        reset   = 1'b1;
        s_valid = 1'b0;
        s_data  = 8'h00;
        s_last  = 1'b0;
`ifdef SM_CONFIG_READBACK_EN
        rb_req   = 1'b0;
        rb_ready = 1'b0;
`endif
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_cfg",   {20'd0, ConfigBits}, 32'h000);
        chk("rst_ready", {31'd0, s_ready},  32'd1);
        chk("rst_busy",  {31'd0, busy},     32'd0);
        chk("rst_done",  {31'd0, cfg_done}, 32'd0);
        chk("rst_err",   {31'd0, cfg_err},  32'd0);
        reset = 1'b0;
        @(posedge CLK);
        #1;

        // Good frame 0xA5, 0x3C -> 0xCA5.
        xfer(8'hA5, 1'b0);
        chk("load_busy", {31'd0, busy}, 32'd1);
        xfer(8'h3C, 1'b1);
        exp_q.push_back(12'hCA5);
        chk("commit_ready_low", {31'd0, s_ready}, 32'd0);
        chk("commit_busy",      {31'd0, busy},    32'd1);
        chk("commit_cfg_old",   {20'd0, ConfigBits}, 32'h000);
        check_commit("f1");

        // Early last: error, image kept, no pulse.
        xfer(8'h11, 1'b1);
        chk("early_err",  {31'd0, cfg_err},  32'd1);
        chk("early_busy", {31'd0, busy},     32'd0);
        chk("early_cfg",  {20'd0, ConfigBits}, 32'hCA5);
        chk("early_done", {31'd0, cfg_done}, 32'd0);
        @(posedge CLK);
        #1;
        chk("early_done2", {31'd0, cfg_done}, 32'd0);

        // Missing last: error after word 1, third word drained.
        xfer(8'h01, 1'b0);
        chk("miss_err_cleared", {31'd0, cfg_err}, 32'd0);
        xfer(8'h02, 1'b0);
        chk("miss_err",        {31'd0, cfg_err}, 32'd1);
        chk("miss_drain_busy", {31'd0, busy},    32'd1);
        xfer(8'h03, 1'b1);
        chk("drain_idle", {31'd0, busy},     32'd0);
        chk("drain_cfg",  {20'd0, ConfigBits}, 32'hCA5);
        chk("drain_done", {31'd0, cfg_done}, 32'd0);
        chk("drain_err",  {31'd0, cfg_err},  32'd1);

        // Recovery frame clears the error and commits 0xFFF.
        xfer(8'hFF, 1'b0);
        chk("recover_err_clr", {31'd0, cfg_err}, 32'd0);
        xfer(8'h0F, 1'b1);
        exp_q.push_back(12'hFFF);
        check_commit("f2");

        // Reset mid-frame discards the partial image.
        xfer(8'h77, 1'b0);
        reset = 1'b1;
        @(posedge CLK);
        #1;
        reset = 1'b0;
        chk("midrst_cfg",  {20'd0, ConfigBits}, 32'h000);
        chk("midrst_busy", {31'd0, busy},       32'd0);
        xfer(8'h12, 1'b0);
        xfer(8'h34, 1'b1);
        exp_q.push_back(12'h412);
        check_commit("f3");

`ifdef SM_CONFIG_READBACK_EN
        xfer(8'hA5, 1'b0);
        xfer(8'h3C, 1'b1);
        exp_q.push_back(12'hCA5);
        check_commit("f4");
        rb_req = 1'b1;
        @(posedge CLK);
        #1;
        rb_req = 1'b0;
        chk("rb_valid0", {31'd0, rb_valid}, 32'd1);
        chk("rb_data0",  {24'd0, rb_data},  32'hA5);
        chk("rb_last0",  {31'd0, rb_last},  32'd0);
        repeat (2) begin
            @(posedge CLK);
            #1;
            chk("rb_hold_data",  {24'd0, rb_data},  32'hA5);
            chk("rb_hold_valid", {31'd0, rb_valid}, 32'd1);
        end
        rb_ready = 1'b1;
        @(posedge CLK);
        #1;
        chk("rb_data1", {24'd0, rb_data}, 32'h0C);
        chk("rb_last1", {31'd0, rb_last}, 32'd1);
        @(posedge CLK);
        #1;
        chk("rb_end_valid", {31'd0, rb_valid}, 32'd0);
        rb_ready = 1'b0;
`endif

        chk("sb_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
